// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the backing-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned LINE_WORDS_DEF = 4;
    localparam int unsigned BEAT_W         = $clog2(LINE_WORDS_DEF);
    localparam int unsigned OFF_W          = BEAT_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not own the last burst wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  owner_t last_owner,
    output logic   grant_valid,
    output owner_t grant_owner
);

    always_comb begin
        grant_valid = req_i | req_d;
        grant_owner = OWN_I;
        if (req_i && req_d) begin
            grant_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (req_d) begin
            grant_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single backing-memory port between Icache refills and Dcache refill/write-back,
// sequencing one cache line per grant and returning a one-cycle done to the owner.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int unsigned ADDR_W     = 32,
    parameter  int unsigned DATA_W     = 32,
    parameter  int unsigned LINE_WORDS = LINE_WORDS_DEF,
    localparam int unsigned BW         = (LINE_WORDS == LINE_WORDS_DEF) ? BEAT_W : $clog2(LINE_WORDS),
    localparam int unsigned OW         = (LINE_WORDS == LINE_WORDS_DEF) ? OFF_W  : BW + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic [BW-1:0]     i_beat,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [BW-1:0]     d_beat,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    localparam int unsigned LINE_W = ADDR_W - OW;

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_q,  last_d;
    logic [LINE_W-1:0] base_q,  base_d;
    logic              we_q,    we_d;
    logic [BW-1:0]     beat_q,  beat_d;

    logic   grant_valid;
    owner_t grant_owner;
    logic   last_beat;

    // Byte/word offsets of the request address are replaced by the beat counter.
    logic unused_offsets;
    assign unused_offsets = ^{i_addr[OW-1:0], d_addr[OW-1:0]};

    rr_pick2 u_pick (
        .req_i       (i_req),
        .req_d       (d_req),
        .last_owner  (last_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign last_beat = (beat_q == BW'(LINE_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_I;
            base_q  <= '0;
            we_q    <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            base_q  <= base_d;
            we_q    <= we_d;
            beat_q  <= beat_d;
        end
    end

    // Beat counter wraps to zero naturally on the final beat (LINE_WORDS is a power of two).
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        base_d  = base_q;
        we_d    = we_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d = ST_BURST;
                    owner_d = grant_owner;
                    base_d  = (grant_owner == OWN_D) ? d_addr[ADDR_W-1:OW] : i_addr[ADDR_W-1:OW];
                    we_d    = (grant_owner == OWN_D) && d_we;
                    beat_d  = '0;
                end
            end
            ST_BURST: begin
                if (mem_ready) begin
                    beat_d = beat_q + BW'(1);
                    if (last_beat) begin
                        state_d = ST_RESP;
                        last_d  = owner_q;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        logic in_burst;
        logic rd_beat;
        in_burst  = (state_q == ST_BURST);
        rd_beat   = in_burst && mem_ready && !we_q;

        mem_req   = in_burst;
        mem_we    = in_burst && we_q;
        mem_addr  = in_burst ? {base_q, beat_q, 2'b00} : '0;
        mem_wdata = (in_burst && we_q) ? d_wdata : '0;

        i_rvalid  = rd_beat && (owner_q == OWN_I);
        d_rvalid  = rd_beat && (owner_q == OWN_D);
        i_rdata   = i_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
        i_beat    = (in_burst && owner_q == OWN_I) ? beat_q : '0;
        d_beat    = (in_burst && owner_q == OWN_D) ? beat_q : '0;

        i_done    = (state_q == ST_RESP) && (owner_q == OWN_I);
        d_done    = (state_q == ST_RESP) && (owner_q == OWN_D);
        busy      = (state_q != ST_IDLE);
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences cache-line bursts on the single shared backing-memory port and shares that port between the Icache refill path and the Dcache refill/write-back path. Each cache raises a line request on a miss. The arbiter grants one requester at a time using round-robin on contention, drives one word per `mem_ready` beat, and returns data and a one-cycle `done` to the owner. It sits between both caches and the rom/ram memory interface. Its `done` pulses are what let the flow controller release the Icache and Dcache stalls.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, word width (4 bytes per word)
- LINE_WORDS, 4, words per line; power of 2, ≥2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_req  in  1  Icache line read request; held until i_done
- i_addr  in  ADDR_W  Icache miss address; any byte within the line
- i_rvalid  out  1  beat valid to Icache
- i_rdata  out  DATA_W  beat data (pass-through of mem_rdata)
- i_beat  out  log2(LINE_WORDS)  word index of the current beat
- i_done  out  1  one-cycle pulse, Icache transaction complete
- d_req  in  1  Dcache line request; held until d_done
- d_we  in  1  1 = line write-back, 0 = refill; stable while d_req is high
- d_addr  in  ADDR_W  Dcache line address
- d_wdata  in  DATA_W  write word for index d_beat; combinational from the Dcache line buffer
- d_rvalid, d_rdata, d_beat, d_done  out  —  as the Icache ports; d_rvalid only on reads
- mem_req  out  1  memory access active
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data
- mem_ready  in  1  beat accepted/returned this cycle
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, BURST, RESP. Registers: owner (I/D), last_owner, base (line address, low log2(LINE_WORDS)+2 bits cleared), we_q, beat counter.
- IDLE:
  - Only i_req high → owner=I.
  - Only d_req high → owner=D.
  - Both high → owner = the requester that was not last_owner.
  - On grant: latch the address into base, latch we_q (I: 0; D: d_we), clear beat, go to BURST.
- BURST:
  - mem_req=1, mem_we=we_q, mem_addr = {base line bits, beat, 2'b00}, mem_wdata = d_wdata (D writes only; 0 otherwise).
  - Each cycle with mem_ready=1: one beat completes. On reads, the owner's rvalid=1 and rdata=mem_rdata in that same cycle. The beat counter increments.
  - mem_ready on beat LINE_WORDS−1 → RESP, last_owner ← owner.
  - A beat is not complete until mem_ready=1; wait states of any length are legal.
- RESP: owner's done=1 for exactly one cycle, mem_req=0, then IDLE. The owner's req is ignored during RESP. The requester deasserts req at the clock edge ending RESP, so a new request is never re-granted spuriously.
- The non-owner's req may rise or stay high at any time; it is serviced on a later IDLE. No starvation: the round-robin policy bounds the wait to one transaction.
- No abort. Once granted, a burst always completes, including an Icache refill after a jump. The Icache discards unwanted data itself.
- mem_ready outside BURST is ignored.
- Reset (asserted at any time, including mid-burst): state=IDLE, owner=I, last_owner=I (so a Dcache request wins the first tie), beat=0, base=0. Every output is 0 on the next evaluation. A burst interrupted by reset is not resumed.

## Timing
- Grant latency: req is sampled high in IDLE at edge t; mem_req=1 from cycle t+1.
- Read data to the requester has zero-cycle latency relative to mem_ready (combinational pass-through).
- With mem_ready tied high: LINE_WORDS BURST cycles, 1 RESP cycle, 1 IDLE cycle. That gives LINE_WORDS+2 cycles from grant to the next grant.
- beat wraps from LINE_WORDS−1 to 0 only on leaving BURST. Address increment never carries into the line bits.
- Outputs `*_rvalid`, `*_beat`, `mem_*` are decoded from registered state plus mem_ready. `done` is decoded from the RESP state (glitch-free per cycle).

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum (IDLE/BURST/RESP)
  - the owner enum (OWN_I/OWN_D)
  - the localparams BEAT_W = $clog2(LINE_WORDS) and OFF_W = BEAT_W+2
- One sub-module: `rr_pick2`, the 2-way round-robin picker. Inputs: req_i, req_d, last_owner. Outputs: grant_valid, grant_owner. Purely combinational; the FSM lives in the parent.

## Test plan
- Icache only:
  - Stimulus: i_addr=0x0000_1238, mem_ready=1 always.
  - Response: mem_addr = 0x1230, 0x1234, 0x1238, 0x123C on cycles t+1..t+4. i_rvalid each of those cycles with i_beat=0..3. i_done on t+5. busy=0 on t+6.
- Dcache write-back with waits:
  - Stimulus: d_we=1, d_addr=0x8000_0010, mem_ready high every other cycle.
  - Response: mem_we=1 and mem_addr holds until each ready. d_wdata is sampled at d_beat=0..3. d_rvalid is never 1. Exactly 8 BURST cycles.
- Simultaneous i_req and d_req out of reset:
  - Response: D is granted first. I is granted in the IDLE immediately after d_done.
  - Repeat both requests: grants alternate D, I, D, I.
- Icache request arriving mid-Dcache burst:
  - Response: no effect on mem_addr or the D beats. I is granted right after D's RESP+IDLE.
- rst_n pulsed low during beat 2:
  - Response: mem_req=0 and busy=0 immediately. After reset, a new i_req restarts at beat 0.
